flit_rx: RTL and testbench
==========================

# flit_rx

Byte-serial flit receiver: accepts a framed byte stream (sync byte, payload bytes LSB-first, XOR checksum byte), reassembles it into one flit and presents it on a valid/ready output through a single-entry output register. It is the receive end of the node-to-node link and sits between the link PHY byte interface and the router input port. Bad or stalled frames are dropped and reported with one-cycle error pulses.

## Interface
- FLIT_WIDTH, 64, flit width in bits; must be a multiple of 8, with N = FLIT_WIDTH/8 payload bytes
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 255, maximum idle cycles allowed between bytes inside a frame (1..255)

Ports:
- clk  input  1  clock; all logic is on the posedge
- rst_n  input  1  reset; one clock, reset synchronous and active-low
- rx_byte  input  8  incoming byte
- rx_valid  input  1  rx_byte valid
- rx_ready  output  1  receiver can accept rx_byte this cycle
- flit_out  output  FLIT_WIDTH  assembled flit
- flit_valid  output  1  flit_out valid
- flit_ready  input  1  consumer accepts flit_out
- checksum_error  output  1  one-cycle pulse: frame dropped on checksum mismatch
- timeout_error  output  1  one-cycle pulse: frame dropped on inter-byte timeout

## Operation
- Byte transfer occurs on a posedge with rx_valid && rx_ready. Flit transfer occurs on a posedge with flit_valid && flit_ready.
- State machine:
  - IDLE: a transferred byte equal to SYNC_BYTE moves to PAYLOAD and clears the byte index and running XOR. Other bytes are consumed and discarded.
  - PAYLOAD: byte k (0..N-1) is written into bits [8k+7:8k] of the assembly register and XORed into the running checksum. Byte N-1 moves to CHECK. SYNC_BYTE values inside the payload are treated as data.
  - CHECK: the transferred byte is compared with the running XOR. On a match, the assembly register loads into the output register and flit_valid is set. On a mismatch, checksum_error pulses and nothing is loaded. Either way the next state is IDLE.
- rx_ready is 1 in IDLE and PAYLOAD. In CHECK, rx_ready = !flit_valid || flit_ready, so an unconsumed flit is never overwritten.
- flit_valid stays high and flit_out stays stable until the flit transfers.
- Timeout:
  - An 8-bit counter clears on every byte transfer and on entry to PAYLOAD.
  - In PAYLOAD or CHECK, the counter increments on each cycle without a byte transfer.
  - When the counter reaches TIMEOUT_CYCLES, timeout_error pulses, the state returns to IDLE and the partial frame is discarded.
  - A backpressure stall in CHECK (rx_valid && !rx_ready) does not count toward the timeout.
- The output register is independent of the FSM: a held flit survives a later error or timeout.

## Timing
- Reset values: rx_ready=0 during reset and 1 from the first cycle after reset; flit_out=0, flit_valid=0, checksum_error=0, timeout_error=0. State is IDLE, counters are 0.
- Reset asserted mid-frame or while a flit is held discards everything on that edge.
- Latency: flit_valid rises on the edge that transfers the checksum byte, i.e. it is visible in the next cycle.
- Full-rate frame: 1 + N + 1 bytes over N+2 cycles; back-to-back frames need no idle cycle.
- Simultaneous flit transfer and checksum-byte transfer in the same cycle: the old flit leaves and the new flit loads, so flit_valid stays 1.
- A timeout and a byte transfer in the same cycle: the byte wins and the counter clears.
- Error pulses are high for exactly one cycle, in the cycle after the causing edge.

## Configuration
- FLIT_RX_CHECKSUM_EN defined: the frame includes the checksum byte and the CHECK state, exactly as described above.
- FLIT_RX_CHECKSUM_EN not defined:
  - There is no CHECK state and frames are sync + N bytes.
  - Byte N-1 commits the flit directly, and the rx_ready backpressure rule applies to byte N-1 instead.
  - checksum_error is tied to 0.

## Test plan
- Reset, then A5,01,02,03,04,05,06,07,08,08 at full rate -> flit_out=64'h0807060504030201 with flit_valid=1 one cycle after the last byte; no error pulses.
- Same frame with checksum 00 -> checksum_error pulses for one cycle; flit_valid stays 0; the following good frame is received correctly.
- Hold flit_ready=0 and send two good frames -> the second frame stalls at its checksum byte (rx_ready=0); raising flit_ready transfers flit 1, and flit 2 appears in the next cycle with no bytes lost.
- Send A5,01,02 then rx_valid=0 for 255 cycles -> timeout_error pulses once, state returns to IDLE; the next full frame is received correctly.
- Leading garbage 00,FF, then a frame whose payload contains A5 -> the garbage is discarded and the A5 appears as payload data in flit_out.
- Assert rst_n=0 for one cycle after the fourth payload byte -> all outputs at reset values; a fresh frame afterwards is received correctly.

Source files
------------

// File: rtl/flit_rx.sv
// Byte-serial flit receiver: sync byte, N payload bytes LSB-first, optional XOR checksum byte.
// Define FLIT_RX_CHECKSUM_EN to include the checksum byte and CHECK state in each frame.
module flit_rx #(
  parameter int         FLIT_WIDTH     = 64,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  checksum_error,
  output logic                  timeout_error
);

  localparam int              N        = FLIT_WIDTH / 8;
  localparam int              IDXW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST     = IDXW'(N - 1);
  localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic [N-1:0][7:0] asm_q, asm_d;
  logic [7:0]        tmo_q;
  logic [FLIT_WIDTH-1:0] flit_q;
  logic              fv_q;
  logic              tmo_err_q;
  logic              hold_ok, xfer, stall, tmo_hit, commit, sync_hit;
`ifdef FLIT_RX_CHECKSUM_EN
  logic [7:0]        xor_q;
  logic              chk_bad, chk_err_q;
`endif

  assign hold_ok = !fv_q || flit_ready;

  // The frame's final byte is held off while an unconsumed flit occupies the output register.
  always_comb begin
`ifdef FLIT_RX_CHECKSUM_EN
    rx_ready = rst_n && (state_q != CHECK || hold_ok);
`else
    rx_ready = rst_n && !(state_q == PAYLOAD && idx_q == LAST && !hold_ok);
`endif
  end

  assign xfer     = rx_valid && rx_ready;
  assign stall    = rx_valid && !rx_ready;
  assign sync_hit = (state_q == IDLE) && xfer && (rx_byte == SYNC_BYTE);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit  = (state_q != IDLE) && !xfer && !stall && (tmo_q == TMO_LAST);

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign asm_d[k] = (state_q == PAYLOAD && xfer && idx_q == IDXW'(k)) ? rx_byte : asm_q[k];
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
`ifdef FLIT_RX_CHECKSUM_EN
    chk_bad = 1'b0;
`endif
    case (state_q)
      IDLE: if (sync_hit) state_d = PAYLOAD;
      PAYLOAD: begin
        if (tmo_hit) state_d = IDLE;
        else if (xfer && idx_q == LAST) begin
`ifdef FLIT_RX_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = IDLE;
          commit  = 1'b1;
`endif
        end
      end
`ifdef FLIT_RX_CHECKSUM_EN
      CHECK: begin
        if (tmo_hit) state_d = IDLE;
        else if (xfer) begin
          state_d = IDLE;
          if (rx_byte == xor_q) commit  = 1'b1;
          else                  chk_bad = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      asm_q     <= '0;
      tmo_q     <= '0;
      flit_q    <= '0;
      fv_q      <= 1'b0;
      tmo_err_q <= 1'b0;
`ifdef FLIT_RX_CHECKSUM_EN
      xor_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      if (sync_hit)                      idx_q <= '0;
      else if (state_q == PAYLOAD && xfer) idx_q <= idx_q + IDXW'(1);
`ifdef FLIT_RX_CHECKSUM_EN
      if (sync_hit)                      xor_q <= '0;
      else if (state_q == PAYLOAD && xfer) xor_q <= xor_q ^ rx_byte;
      chk_err_q <= chk_bad;
`endif
      // Backpressure stalls are not idle time.
      if (xfer || tmo_hit)                   tmo_q <= '0;
      else if (state_q != IDLE && !stall)    tmo_q <= tmo_q + 8'd1;
      // Output register is independent of the FSM; a load and an unload may coincide.
      if (commit) begin
        flit_q <= asm_d;
        fv_q   <= 1'b1;
      end else if (fv_q && flit_ready) begin
        fv_q   <= 1'b0;
      end
      tmo_err_q <= tmo_hit;
    end
  end

  assign flit_out      = flit_q;
  assign flit_valid    = fv_q;
  assign timeout_error = tmo_err_q;
`ifdef FLIT_RX_CHECKSUM_EN
  assign checksum_error = chk_err_q;
`else
  assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_flit_rx.sv
// Directed bench for flit_rx: framing, checksum, backpressure, timeout, garbage and reset.
module tb_flit_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic        checksum_error;
  logic        timeout_error;

  int tests = 0;
  int fails = 0;

  flit_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .checksum_error(checksum_error), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b; step();
  endtask

  // Sync plus every byte but the frame's last one.
  task automatic frame_body(input logic [63:0] p);
    send_byte(8'hA5);
    for (int k = 0; k < 7; k++) send_byte(p[8*k +: 8]);
`ifdef FLIT_RX_CHECKSUM_EN
    send_byte(p[63:56]);
`endif
  endtask

  function automatic logic [7:0] last_byte(input logic [63:0] p, input logic [7:0] ck);
`ifdef FLIT_RX_CHECKSUM_EN
    return ck;
`else
    return p[63:56];
`endif
  endfunction

  task automatic send_frame(input logic [63:0] p, input logic [7:0] ck);
    frame_body(p);
    send_byte(last_byte(p, ck));
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n_pulse, at;
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; flit_ready = 1'b0;
    step(); step();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_flit_valid", flit_valid, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_chk_err", checksum_error, 0);
    chk("rst_tmo_err", timeout_error, 0);
    rst_n = 1'b1; step();
    chk("post_rst_rx_ready", rx_ready, 1);

    // Good frame at full rate
    send_frame(64'h0807060504030201, 8'h08);
    rx_valid = 1'b0;
    chk("f1_valid", flit_valid, 1);
    chk("f1_data", flit_out, 64'h0807060504030201);
    chk("f1_chk_err", checksum_error, 0);
    chk("f1_tmo_err", timeout_error, 0);
    flit_ready = 1'b1; step();
    chk("f1_consumed", flit_valid, 0);
    flit_ready = 1'b0;

`ifdef FLIT_RX_CHECKSUM_EN
    // Bad checksum: pulse for one cycle, nothing loaded
    send_frame(64'h0807060504030201, 8'h00);
    rx_valid = 1'b0;
    chk("bad_ck_pulse", checksum_error, 1);
    chk("bad_ck_no_flit", flit_valid, 0);
    step();
    chk("bad_ck_pulse_end", checksum_error, 0);
`endif
    send_frame(64'h8877665544332211, 8'h88);
    rx_valid = 1'b0;
    chk("f2_data", flit_out, 64'h8877665544332211);
    chk("f2_valid", flit_valid, 1);
    chk("f2_chk_err", checksum_error, 0);
    flit_ready = 1'b1; step(); flit_ready = 1'b0;

    // Back-to-back frames with the consumer stalled
    send_frame(64'h0807060504030201, 8'h08);
    frame_body(64'h8877665544332211);
    rx_valid = 1'b1; rx_byte = last_byte(64'h8877665544332211, 8'h88);
    chk("bp_stall_ready", rx_ready, 0);
    n_pulse = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (timeout_error) n_pulse++;
    end
    chk("bp_stall_no_tmo", n_pulse, 0);
    chk("bp_still_ready0", rx_ready, 0);
    chk("bp_hold_data", flit_out, 64'h0807060504030201);
    flit_ready = 1'b1; #1;
    chk("bp_ready_release", rx_ready, 1);
    step();
    rx_valid = 1'b0;
    chk("bp_f2_valid", flit_valid, 1);
    chk("bp_f2_data", flit_out, 64'h8877665544332211);
    step();
    chk("bp_drained", flit_valid, 0);
    flit_ready = 1'b0;

    // Inter-byte timeout
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    rx_valid = 1'b0;
    n_pulse = 0; at = 0;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (timeout_error) begin n_pulse++; at = i; end
    end
    chk("tmo_count", n_pulse, 1);
    chk("tmo_cycle", at, 255);
    chk("tmo_no_flit", flit_valid, 0);
    send_frame(64'h0807060504030201, 8'h08);
    rx_valid = 1'b0;
    chk("tmo_next_data", flit_out, 64'h0807060504030201);
    chk("tmo_next_valid", flit_valid, 1);
    flit_ready = 1'b1; step(); flit_ready = 1'b0;

    // Leading garbage, sync value inside the payload
    send_byte(8'h00); send_byte(8'hFF);
    send_frame(64'h70605040_3020A510, 8'hA5);
    rx_valid = 1'b0;
    chk("garb_data", flit_out, 64'h70605040_3020A510);
    chk("garb_valid", flit_valid, 1);
    chk("garb_chk_err", checksum_error, 0);

    // Reset mid-frame with a flit held
    send_byte(8'hA5);
    for (int k = 0; k < 4; k++) send_byte(8'hC0 + 8'(k));
    rx_valid = 1'b0; rst_n = 1'b0;
    step();
    chk("mid_rst_valid", flit_valid, 0);
    chk("mid_rst_data", flit_out, 0);
    chk("mid_rst_ready", rx_ready, 0);
    chk("mid_rst_chk_err", checksum_error, 0);
    chk("mid_rst_tmo_err", timeout_error, 0);
    rst_n = 1'b1;
    send_frame(64'h1122334455667788, 8'h88);
    rx_valid = 1'b0;
    chk("post_rst_data", flit_out, 64'h1122334455667788);
    chk("post_rst_valid", flit_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
